vc_pop_arbiter: RTL and testbench

Sequences the VC0/VC1 FIFO pops that feed the VC mux and the destination demux in the QoS path. Each cycle it picks at most one virtual channel, using strict VC0 priority with a bounded-starvation escape for VC1. A VC is picked only when the head word's destination FIFO (D0/D1) is not almost-full. It drives the pops combinationally and registers the mux select, destination select and valid so they align with the 1-cycle FIFO read latency. It is enabled by the active indication from the init/condition state machine.

---
 rtl/vc_pop_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_vc_pop_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter
// Picks at most one of VC0/VC1 to pop each cycle. VC0 has strict priority,
// but VC1 is forced through after STARVE_MAX consecutive VC0 wins while it
// was eligible. A VC is eligible only when it is non-empty and its head
// word's destination FIFO is not almost-full. Pops are combinational. The
// mux select, destination select and valid are registered so that they
// line up with the 1-cycle FIFO read latency.
module vc_pop_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int SC_W       = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             VC0_empty,
    input  logic             VC1_empty,
    input  logic             VC0_head_dest,
    input  logic             VC1_head_dest,
    input  logic             D0_almost_full,
    input  logic             D1_almost_full,
    output logic             VC0_pop,
    output logic             VC1_pop,
    output logic             mux_sel,
    output logic             dest_sel,
    output logic             data_valid,
    output logic [CNT_W-1:0] VC0_grants,
    output logic [CNT_W-1:0] VC1_grants,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    localparam logic [SC_W-1:0]  STARVE_MAX_C = SC_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};

    state_t             state_r;
    logic               busy_r;
    logic [SC_W-1:0]    starve_cnt_r;
    logic               mux_sel_r;
    logic               dest_sel_r;
    logic               data_valid_r;
    logic [CNT_W-1:0]   vc0_grants_r;
    logic [CNT_W-1:0]   vc1_grants_r;

    logic               e0_s;
    logic               e1_s;
    logic               arb_active_s;
    logic               grant0_s;
    logic               grant1_s;

    // A VC may go only if it has a word and that word's target FIFO has room.
    function automatic logic is_eligible(
        input logic empty,
        input logic head_dest,
        input logic d0_af,
        input logic d1_af
    );
        logic dest_af;
        dest_af = head_dest ? d1_af : d0_af;
        return (!empty) && (!dest_af);
    endfunction

    // Saturating increment for the per-VC grant counters (never wraps).
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX_C) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign e0_s         = is_eligible(VC0_empty, VC0_head_dest, D0_almost_full, D1_almost_full);
    assign e1_s         = is_eligible(VC1_empty, VC1_head_dest, D0_almost_full, D1_almost_full);
    assign arb_active_s = (state_r == ST_ARB) && enable;

    // Grant decision: VC0 priority with a forced VC1 turn once starvation hits the limit.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (arb_active_s) begin
            case ({e0_s, e1_s})
                2'b10: grant0_s = 1'b1;
                2'b01: grant1_s = 1'b1;
                2'b11: begin
                    if (starve_cnt_r == STARVE_MAX_C) begin
                        grant1_s = 1'b1;
                    end else begin
                        grant0_s = 1'b1;
                    end
                end
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign VC0_pop = grant0_s;
    assign VC1_pop = grant1_s;

    // Control FSM: arbitrate only while the upstream state machine reports active.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r <= ST_ARB;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_ARB: begin
                    if (!enable) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_ARB;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Starvation tracking: counts VC0 wins that VC1 could have taken; kept across IDLE.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (grant1_s) begin
            starve_cnt_r <= {SC_W{1'b0}};
        end else if (grant0_s && e1_s) begin
            if (starve_cnt_r >= STARVE_MAX_C) begin
                starve_cnt_r <= STARVE_MAX_C;
            end else begin
                starve_cnt_r <= starve_cnt_r + SC_W'(1);
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Output stage: tag the word arriving next cycle with its source VC and destination.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            mux_sel_r    <= 1'b0;
            dest_sel_r   <= 1'b0;
            data_valid_r <= 1'b0;
        end else if (grant0_s) begin
            mux_sel_r    <= 1'b0;
            dest_sel_r   <= VC0_head_dest;
            data_valid_r <= 1'b1;
        end else if (grant1_s) begin
            mux_sel_r    <= 1'b1;
            dest_sel_r   <= VC1_head_dest;
            data_valid_r <= 1'b1;
        end else begin
            mux_sel_r    <= mux_sel_r;
            dest_sel_r   <= dest_sel_r;
            data_valid_r <= 1'b0;
        end
    end

    // Per-VC grant statistics, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            vc0_grants_r <= {CNT_W{1'b0}};
            vc1_grants_r <= {CNT_W{1'b0}};
        end else begin
            if (grant0_s) begin
                vc0_grants_r <= cnt_inc(vc0_grants_r);
            end else begin
                vc0_grants_r <= vc0_grants_r;
            end
            if (grant1_s) begin
                vc1_grants_r <= cnt_inc(vc1_grants_r);
            end else begin
                vc1_grants_r <= vc1_grants_r;
            end
        end
    end

    assign mux_sel    = mux_sel_r;
    assign dest_sel   = dest_sel_r;
    assign data_valid = data_valid_r;
    assign VC0_grants = vc0_grants_r;
    assign VC1_grants = vc1_grants_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed testbench for vc_pop_arbiter (STARVE_MAX=4, SC_W=3, CNT_W=8).
module tb_vc_pop_arbiter;

    logic       clk;
    logic       reset_L;
    logic       enable;
    logic       VC0_empty;
    logic       VC1_empty;
    logic       VC0_head_dest;
    logic       VC1_head_dest;
    logic       D0_almost_full;
    logic       D1_almost_full;
    logic       VC0_pop;
    logic       VC1_pop;
    logic       mux_sel;
    logic       dest_sel;
    logic       data_valid;
    logic [7:0] VC0_grants;
    logic [7:0] VC1_grants;
    logic       busy;

    int tests_run;
    int tests_failed;

    vc_pop_arbiter #(
        .STARVE_MAX(4),
        .SC_W(3),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .enable(enable),
        .VC0_empty(VC0_empty),
        .VC1_empty(VC1_empty),
        .VC0_head_dest(VC0_head_dest),
        .VC1_head_dest(VC1_head_dest),
        .D0_almost_full(D0_almost_full),
        .D1_almost_full(D1_almost_full),
        .VC0_pop(VC0_pop),
        .VC1_pop(VC1_pop),
        .mux_sel(mux_sel),
        .dest_sel(dest_sel),
        .data_valid(data_valid),
        .VC0_grants(VC0_grants),
        .VC1_grants(VC1_grants),
        .busy(busy)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset with both FIFOs non-empty and enable high.
        reset_L        = 1'b0;
        enable         = 1'b1;
        VC0_empty      = 1'b0;
        VC1_empty      = 1'b0;
        VC0_head_dest  = 1'b0;
        VC1_head_dest  = 1'b0;
        D0_almost_full = 1'b0;
        D1_almost_full = 1'b0;
        tick();
        tick();
        check_eq("rst_vc0_pop", {31'd0, VC0_pop}, 32'd0);
        check_eq("rst_vc1_pop", {31'd0, VC1_pop}, 32'd0);
        check_eq("rst_valid", {31'd0, data_valid}, 32'd0);
        check_eq("rst_mux", {31'd0, mux_sel}, 32'd0);
        check_eq("rst_dest", {31'd0, dest_sel}, 32'd0);
        check_eq("rst_g0", {24'd0, VC0_grants}, 32'd0);
        check_eq("rst_g1", {24'd0, VC1_grants}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);

        // Release reset; still IDLE for this cycle, so no pop yet.
        reset_L   = 1'b1;
        VC1_empty = 1'b1;
        #1;
        check_eq("idle_no_pop", {31'd0, VC0_pop}, 32'd0);
        tick();
        check_eq("arb_busy", {31'd0, busy}, 32'd1);

        // VC0 only, dest D0, three pops.
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("b_vc0_pop", {31'd0, VC0_pop}, 32'd1);
            check_eq("b_vc1_pop", {31'd0, VC1_pop}, 32'd0);
            tick();
            check_eq("b_valid", {31'd0, data_valid}, 32'd1);
            check_eq("b_mux", {31'd0, mux_sel}, 32'd0);
            check_eq("b_dest", {31'd0, dest_sel}, 32'd0);
            check_eq("b_g0", {24'd0, VC0_grants}, i + 1);
        end
        VC0_empty = 1'b1;
        #1;
        check_eq("b_empty_no_pop", {31'd0, VC0_pop}, 32'd0);
        tick();
        check_eq("b_valid_off", {31'd0, data_valid}, 32'd0);
        check_eq("b_g0_final", {24'd0, VC0_grants}, 32'd3);

        // Both eligible: VC0 x4 then VC1, repeating. VC1 heads to D1.
        VC0_empty     = 1'b0;
        VC1_empty     = 1'b0;
        VC1_head_dest = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_eq("c_vc0_pop", {31'd0, VC0_pop}, (i % 5 == 4) ? 32'd0 : 32'd1);
            check_eq("c_vc1_pop", {31'd0, VC1_pop}, (i % 5 == 4) ? 32'd1 : 32'd0);
            tick();
            check_eq("c_valid", {31'd0, data_valid}, 32'd1);
            check_eq("c_mux", {31'd0, mux_sel}, (i % 5 == 4) ? 32'd1 : 32'd0);
            check_eq("c_dest", {31'd0, dest_sel}, (i % 5 == 4) ? 32'd1 : 32'd0);
        end
        check_eq("c_g0", {24'd0, VC0_grants}, 32'd11);
        check_eq("c_g1", {24'd0, VC1_grants}, 32'd2);

        // VC0 blocked by D1 almost-full; VC1 to D0 goes instead.
        VC0_head_dest  = 1'b1;
        VC1_head_dest  = 1'b0;
        D1_almost_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("d_vc0_blocked", {31'd0, VC0_pop}, 32'd0);
            check_eq("d_vc1_pop", {31'd0, VC1_pop}, 32'd1);
            tick();
            check_eq("d_mux", {31'd0, mux_sel}, 32'd1);
            check_eq("d_dest", {31'd0, dest_sel}, 32'd0);
        end
        D1_almost_full = 1'b0;
        #1;
        check_eq("d_vc0_resume", {31'd0, VC0_pop}, 32'd1);
        check_eq("d_vc1_idle", {31'd0, VC1_pop}, 32'd0);
        tick();
        check_eq("d_mux0", {31'd0, mux_sel}, 32'd0);
        check_eq("d_dest1", {31'd0, dest_sel}, 32'd1);

        // enable dropped for one cycle mid-stream; starvation count (now 1) survives.
        #1;
        check_eq("e_pre_pop", {31'd0, VC0_pop}, 32'd1);
        tick();
        enable = 1'b0;
        #1;
        check_eq("e_drop_vc0", {31'd0, VC0_pop}, 32'd0);
        check_eq("e_drop_vc1", {31'd0, VC1_pop}, 32'd0);
        check_eq("e_inflight_valid", {31'd0, data_valid}, 32'd1);
        tick();
        check_eq("e_valid_off", {31'd0, data_valid}, 32'd0);
        check_eq("e_idle_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        #1;
        check_eq("e_idle_no_pop", {31'd0, VC0_pop}, 32'd0);
        tick();
        check_eq("e_rearm_busy", {31'd0, busy}, 32'd1);
        check_eq("e_resume1", {31'd0, VC0_pop}, 32'd1);
        tick();
        check_eq("e_resume2", {31'd0, VC0_pop}, 32'd1);
        tick();
        check_eq("e_forced_vc1", {31'd0, VC1_pop}, 32'd1);
        check_eq("e_forced_vc0", {31'd0, VC0_pop}, 32'd0);
        tick();
        check_eq("e_g0", {24'd0, VC0_grants}, 32'd15);
        check_eq("e_g1", {24'd0, VC1_grants}, 32'd5);

        // Saturation: VC0 alone for 250 more pops (265 total).
        VC1_empty     = 1'b1;
        VC0_head_dest = 1'b0;
        repeat (239) tick();
        check_eq("f_g0_254", {24'd0, VC0_grants}, 32'd254);
        tick();
        check_eq("f_g0_255", {24'd0, VC0_grants}, 32'd255);
        repeat (10) tick();
        check_eq("f_g0_sat", {24'd0, VC0_grants}, 32'd255);
        check_eq("f_g1_hold", {24'd0, VC1_grants}, 32'd5);

        // D0 almost-full blocks a D0-bound head; D1-bound head passes.
        D0_almost_full = 1'b1;
        #1;
        check_eq("g_d0_af_block", {31'd0, VC0_pop}, 32'd0);
        tick();
        check_eq("g_d0_af_valid", {31'd0, data_valid}, 32'd0);
        VC0_head_dest = 1'b1;
        #1;
        check_eq("g_d1_pass", {31'd0, VC0_pop}, 32'd1);
        tick();
        check_eq("g_d1_valid", {31'd0, data_valid}, 32'd1);
        check_eq("g_d1_dest", {31'd0, dest_sel}, 32'd1);

        // Empty VCs are never popped whatever their head_dest says.
        VC0_empty      = 1'b1;
        VC1_empty      = 1'b1;
        VC1_head_dest  = 1'b1;
        D0_almost_full = 1'b0;
        #1;
        check_eq("g_empty_vc0", {31'd0, VC0_pop}, 32'd0);
        check_eq("g_empty_vc1", {31'd0, VC1_pop}, 32'd0);
        tick();
        check_eq("g_empty_valid", {31'd0, data_valid}, 32'd0);
        check_eq("g_dest_hold", {31'd0, dest_sel}, 32'd1);

        // Reset mid-stream discards the in-flight valid.
        VC0_empty = 1'b0;
        #1;
        check_eq("h_pop", {31'd0, VC0_pop}, 32'd1);
        tick();
        check_eq("h_inflight", {31'd0, data_valid}, 32'd1);
        reset_L = 1'b0;
        tick();
        check_eq("h_valid_cleared", {31'd0, data_valid}, 32'd0);
        check_eq("h_dest_cleared", {31'd0, dest_sel}, 32'd0);
        check_eq("h_g0_cleared", {24'd0, VC0_grants}, 32'd0);
        check_eq("h_g1_cleared", {24'd0, VC1_grants}, 32'd0);
        check_eq("h_busy_cleared", {31'd0, busy}, 32'd0);
        check_eq("h_no_pop", {31'd0, VC0_pop}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
